// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sweeps a 16x16 key sprite out of the image loader into VGA plot strobes.
// Screen coordinates travel beside each ROM address so they meet the colour when it returns.
module sprite_blitter #(
   parameter int          SPR_W   = 16,
   parameter int          SPR_H   = 16,
   parameter int          ROM_LAT = 1,
   parameter int          SCR_W   = 160,
   parameter int          SCR_H   = 120,
   parameter logic [2:0]  TRANSP  = 3'b000
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] loc_x_i,
   input  logic [7:0] loc_y_i,
   input  logic [2:0] spr_id_i,
   input  logic [1:0] spr_key_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [2:0] img_id_o,
   output logic [1:0] img_key_o,
   output logic [3:0] img_i_o,
   output logic [5:0] img_j_o,
   input  logic [2:0] img_colour_i,
   output logic [7:0] vga_x_o,
   output logic [6:0] vga_y_o,
   output logic [2:0] vga_colour_o,
   output logic       vga_plot_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t state_q, state_d;
   logic [7:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;
   logic [2:0] id_q, id_d;
   logic [1:0] key_q, key_d;
   logic [3:0] i_q, i_d;
   logic [5:0] j_q, j_d;
   logic [7:0] drain_q, drain_d;

   logic [ROM_LAT-1:0]      dv_q, dv_d;
   logic [ROM_LAT-1:0][8:0] dpx_q, dpx_d, dpy_q, dpy_d;

   logic [7:0] vx_q, vx_d;
   logic [6:0] vy_q, vy_d;
   logic [2:0] vc_q, vc_d;
   logic       vp_q, vp_d;

   logic       last_addr;
   logic       tail_v;
   logic [8:0] tail_px, tail_py;

   assign last_addr = (i_q == 4'(SPR_W - 1)) && (j_q == 6'(SPR_H - 1));
   assign tail_v    = dv_q[ROM_LAT-1];
   assign tail_px   = dpx_q[ROM_LAT-1];
   assign tail_py   = dpy_q[ROM_LAT-1];

   always_comb begin
      state_d = state_q;
      loc_x_d = loc_x_q;
      loc_y_d = loc_y_q;
      id_d    = id_q;
      key_d   = key_q;
      i_d     = i_q;
      j_d     = j_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               loc_x_d = loc_x_i;
               loc_y_d = loc_y_i;
               id_d    = spr_id_i;
               key_d   = spr_key_i;
               i_d     = '0;
               j_d     = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (last_addr) begin
               i_d     = '0;
               j_d     = '0;
               drain_d = '0;
               state_d = DRAIN;
            end else if (i_q == 4'(SPR_W - 1)) begin
               i_d = '0;
               j_d = j_q + 6'd1;
            end else begin
               i_d = i_q + 4'd1;
            end
         end
         // ROM_LAT cycles for the loader plus one for the output register
         DRAIN: begin
            if (drain_q == 8'(ROM_LAT)) state_d = DONE;
            else                        drain_d = drain_q + 8'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dv_d  = dv_q;
      dpx_d = dpx_q;
      dpy_d = dpy_q;
      for (int k = ROM_LAT - 1; k > 0; k--) begin
         dv_d[k]  = dv_q[k-1];
         dpx_d[k] = dpx_q[k-1];
         dpy_d[k] = dpy_q[k-1];
      end
      dv_d[0]  = (state_q == FETCH);
      dpx_d[0] = {1'b0, loc_x_q} + 9'(i_q);
      dpy_d[0] = {1'b0, loc_y_q} + 9'(j_q);
   end

   always_comb begin
      vp_d = tail_v && (tail_px < 9'(SCR_W)) && (tail_py < 9'(SCR_H)) &&
             (img_colour_i != TRANSP);
      vx_d = vx_q;
      vy_d = vy_q;
      vc_d = vc_q;
      if (vp_d) begin
         vx_d = tail_px[7:0];
         vy_d = tail_py[6:0];
         vc_d = img_colour_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         loc_x_q <= '0;
         loc_y_q <= '0;
         id_q    <= '0;
         key_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         drain_q <= '0;
         dv_q    <= '0;
         dpx_q   <= '0;
         dpy_q   <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vc_q    <= '0;
         vp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         loc_x_q <= loc_x_d;
         loc_y_q <= loc_y_d;
         id_q    <= id_d;
         key_q   <= key_d;
         i_q     <= i_d;
         j_q     <= j_d;
         drain_q <= drain_d;
         dv_q    <= dv_d;
         dpx_q   <= dpx_d;
         dpy_q   <= dpy_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vc_q    <= vc_d;
         vp_q    <= vp_d;
      end
   end

   assign busy_o       = (state_q == FETCH) || (state_q == DRAIN);
   assign done_o       = (state_q == DONE);
   assign img_id_o     = id_q;
   assign img_key_o    = key_q;
   assign img_i_o      = i_q;
   assign img_j_o      = j_q;
   assign vga_x_o      = vx_q;
   assign vga_y_o      = vy_q;
   assign vga_colour_o = vc_q;
   assign vga_plot_o   = vp_q;

endmodule
